reg_file: RTL and testbench

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and beside decode. It holds the 32 committed integer register values. It records which ROB entry will produce each busy register, and it supplies decode with either a ready value or the producing ROB position for rs1 and rs2. Committed results are written in program order from the ROB. A rollback discards all in-flight rename tags.

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_if.sv | 47 ++++
 rtl/reg_file.sv | 122 ++++++++++++
 tb/tb_reg_file.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file.
package reg_file_pkg;

    localparam int unsigned REG_POS_WID = 5;
    localparam int unsigned REG_NUM     = 1 << REG_POS_WID;
    localparam int unsigned DATA_WID    = 32;
    localparam int unsigned ROB_POS_WID = 4;
    localparam int unsigned ROB_SIZE    = 1 << ROB_POS_WID;

    typedef logic [REG_POS_WID-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_if.sv
// Decode / commit / rollback bundle between the pipeline and the register file.
//   master: decode + ROB side (drives requests, consumes source reads)
//   slave : register file (consumes requests, drives source reads)
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_WID,
    parameter int unsigned ROB_POS_W = ROB_POS_WID
);

    logic                 rollback;

    logic                 decode;
    reg_idx_t             decode_rd;
    logic [ROB_POS_W-1:0] decode_rob_pos;
    reg_idx_t             decode_rs1;
    reg_idx_t             decode_rs2;

    logic [DATA_W-1:0]    rs1_val;
    logic                 rs1_busy;
    logic [ROB_POS_W-1:0] rs1_rob_pos;
    logic [DATA_W-1:0]    rs2_val;
    logic                 rs2_busy;
    logic [ROB_POS_W-1:0] rs2_rob_pos;

    logic                 reg_commit;
    reg_idx_t             reg_commit_rd;
    logic [DATA_W-1:0]    reg_commit_val;
    logic [ROB_POS_W-1:0] reg_commit_rob_pos;

    modport master (
        output rollback,
        output decode, decode_rd, decode_rob_pos, decode_rs1, decode_rs2,
        input  rs1_val, rs1_busy, rs1_rob_pos,
        input  rs2_val, rs2_busy, rs2_rob_pos,
        output reg_commit, reg_commit_rd, reg_commit_val, reg_commit_rob_pos
    );

    modport slave (
        input  rollback,
        input  decode, decode_rd, decode_rob_pos, decode_rs1, decode_rs2,
        output rs1_val, rs1_busy, rs1_rob_pos,
        output rs2_val, rs2_busy, rs2_rob_pos,
        input  reg_commit, reg_commit_rd, reg_commit_val, reg_commit_rob_pos
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   rdy  - global clock enable; all state holds while low
//   bus  - reg_file_if.slave: rollback, decode rename request, two source
//          read ports (combinational, with commit bypass), ROB commit port
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_CNT   = REG_NUM,
    parameter int unsigned DATA_W    = DATA_WID,
    parameter int unsigned ROB_POS_W = ROB_POS_WID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    reg_file_if.slave  bus
);

    localparam int unsigned RD_W = DATA_W + 1 + ROB_POS_W;

    logic [DATA_W-1:0]    val_q  [REG_CNT];
    logic [DATA_W-1:0]    val_d  [REG_CNT];
    logic [REG_CNT-1:0]   busy_q;
    logic [REG_CNT-1:0]   busy_d;
    logic [ROB_POS_W-1:0] tag_q  [REG_CNT];
    logic [ROB_POS_W-1:0] tag_d  [REG_CNT];

    logic commit_en;
    logic rename_en;

    // One source read: x0 is constant zero; a matching commit this cycle
    // bypasses its value and reports the source as ready.
    function automatic logic [RD_W-1:0] read_port(
        input reg_idx_t             rs,
        input logic                 busy,
        input logic [ROB_POS_W-1:0] tag,
        input logic [DATA_W-1:0]    val,
        input logic                 c_en,
        input reg_idx_t             c_rd,
        input logic [ROB_POS_W-1:0] c_pos,
        input logic [DATA_W-1:0]    c_val
    );
        logic [DATA_W-1:0]    v;
        logic                 b;
        logic [ROB_POS_W-1:0] p;
        v = '0;
        b = 1'b0;
        p = '0;
        if (rs != '0) begin
            if (busy && c_en && (c_rd == rs) && (tag == c_pos)) begin
                v = c_val;
            end else begin
                v = val;
                b = busy;
                p = busy ? tag : '0;
            end
        end
        return {v, b, p};
    endfunction

    always_comb begin
        commit_en = bus.reg_commit && (bus.reg_commit_rd != '0);
        rename_en = bus.decode && !bus.rollback && (bus.decode_rd != '0);
    end

    // Next state; later assignments implement rollback > rename > commit clear.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (commit_en) begin
                val_d[bus.reg_commit_rd] = bus.reg_commit_val;
                // A tag mismatch means a younger producer still owns the register.
                if (tag_q[bus.reg_commit_rd] == bus.reg_commit_rob_pos) begin
                    busy_d[bus.reg_commit_rd] = 1'b0;
                end
            end
            if (bus.rollback) begin
                busy_d = '0;
                for (int i = 0; i < REG_CNT; i++) begin
                    tag_d[i] = '0;
                end
            end else if (rename_en) begin
                busy_d[bus.decode_rd] = 1'b1;
                tag_d[bus.decode_rd]  = bus.decode_rob_pos;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_CNT; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < REG_CNT; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Source read ports.
    always_comb begin
        {bus.rs1_val, bus.rs1_busy, bus.rs1_rob_pos} = read_port(
            bus.decode_rs1, busy_q[bus.decode_rs1], tag_q[bus.decode_rs1],
            val_q[bus.decode_rs1], bus.reg_commit, bus.reg_commit_rd,
            bus.reg_commit_rob_pos, bus.reg_commit_val);
        {bus.rs2_val, bus.rs2_busy, bus.rs2_rob_pos} = read_port(
            bus.decode_rs2, busy_q[bus.decode_rs2], tag_q[bus.decode_rs2],
            val_q[bus.decode_rs2], bus.reg_commit, bus.reg_commit_rd,
            bus.reg_commit_rob_pos, bus.reg_commit_val);
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(32), .ROB_POS_W(4)) bus ();

    reg_file #(.REG_CNT(32), .DATA_W(32), .ROB_POS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // Reference model: committed values, busy flags, producer tags.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    // Apply one clock edge of architectural rules to the model.
    task automatic model_edge();
        int crd;
        int drd;
        crd = int'(bus.reg_commit_rd);
        drd = int'(bus.decode_rd);
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else if (rdy) begin
            if (bus.reg_commit && crd != 0) begin
                m_val[crd] = bus.reg_commit_val;
                if (m_tag[crd] == bus.reg_commit_rob_pos &&
                    !(bus.decode && !bus.rollback && drd == crd))
                    m_busy[crd] = 0;
            end
            if (bus.rollback) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 0; m_tag[i] = 0;
                end
            end else if (bus.decode && drd != 0) begin
                m_busy[drd] = 1;
                m_tag[drd]  = bus.decode_rob_pos;
            end
        end
    endtask

    // Expected read of one source from the model, including commit bypass.
    task automatic model_read(input int rs, output logic [31:0] v,
                              output logic b, output logic [3:0] p);
        v = 0; b = 0; p = 0;
        if (rs != 0) begin
            if (m_busy[rs] && bus.reg_commit && int'(bus.reg_commit_rd) == rs &&
                m_tag[rs] == bus.reg_commit_rob_pos) begin
                v = bus.reg_commit_val;
            end else begin
                v = m_val[rs];
                b = m_busy[rs];
                p = m_busy[rs] ? m_tag[rs] : 4'd0;
            end
        end
    endtask

    task automatic idle();
        rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.decode = 1'b0; bus.decode_rd = '0; bus.decode_rob_pos = '0;
        bus.decode_rs1 = '0; bus.decode_rs2 = '0;
        bus.reg_commit = 1'b0; bus.reg_commit_rd = '0;
        bus.reg_commit_val = '0; bus.reg_commit_rob_pos = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.decode_rs1 = 5'd5; bus.decode_rs2 = 5'd5;
        #1;
        tests++;
        if (bus.rs1_val !== 32'd0 || bus.rs1_busy !== 1'b0 || bus.rs1_rob_pos !== 4'd0) begin
            $display("FAIL reset_rs1 got val=%h busy=%b pos=%0d want 0/0/0",
                     bus.rs1_val, bus.rs1_busy, bus.rs1_rob_pos);
            fails++;
        end
        tests++;
        if (bus.rs2_val !== 32'd0 || bus.rs2_busy !== 1'b0) begin
            $display("FAIL reset_rs2 got val=%h busy=%b want 0/0", bus.rs2_val, bus.rs2_busy);
            fails++;
        end
    endtask

    task automatic test_rename_commit();
        idle();
        bus.decode = 1'b1; bus.decode_rd = 5'd5; bus.decode_rob_pos = 4'd3;
        step();
        idle(); bus.decode_rs1 = 5'd5; #1;
        tests++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_rob_pos !== 4'd3) begin
            $display("FAIL rename_x5 got busy=%b pos=%0d want 1/3", bus.rs1_busy, bus.rs1_rob_pos);
            fails++;
        end
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd5;
        bus.reg_commit_rob_pos = 4'd3; bus.reg_commit_val = 32'h1234;
        step();
        idle(); bus.decode_rs1 = 5'd5; #1;
        tests++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'h1234 || bus.rs1_rob_pos !== 4'd0) begin
            $display("FAIL commit_x5 got val=%h busy=%b pos=%0d want 1234/0/0",
                     bus.rs1_val, bus.rs1_busy, bus.rs1_rob_pos);
            fails++;
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.decode = 1'b1; bus.decode_rd = 5'd7; bus.decode_rob_pos = 4'd2;
        step();
        idle();
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd7;
        bus.reg_commit_rob_pos = 4'd2; bus.reg_commit_val = 32'hAA;
        bus.decode_rs1 = 5'd7;
        #1;
        tests++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'hAA || bus.rs1_rob_pos !== 4'd0) begin
            $display("FAIL bypass_x7 got val=%h busy=%b pos=%0d want aa/0/0",
                     bus.rs1_val, bus.rs1_busy, bus.rs1_rob_pos);
            fails++;
        end
        step();
    endtask

    task automatic test_waw();
        idle();
        bus.decode = 1'b1; bus.decode_rd = 5'd9; bus.decode_rob_pos = 4'd1;
        step();
        bus.decode_rob_pos = 4'd4;
        step();
        idle();
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd9;
        bus.reg_commit_rob_pos = 4'd1; bus.reg_commit_val = 32'h11;
        step();
        idle(); bus.decode_rs2 = 5'd9; #1;
        tests++;
        if (bus.rs2_val !== 32'h11 || bus.rs2_busy !== 1'b1 || bus.rs2_rob_pos !== 4'd4) begin
            $display("FAIL waw_stale got val=%h busy=%b pos=%0d want 11/1/4",
                     bus.rs2_val, bus.rs2_busy, bus.rs2_rob_pos);
            fails++;
        end
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd9;
        bus.reg_commit_rob_pos = 4'd4; bus.reg_commit_val = 32'h22;
        step();
        idle(); bus.decode_rs2 = 5'd9; #1;
        tests++;
        if (bus.rs2_val !== 32'h22 || bus.rs2_busy !== 1'b0) begin
            $display("FAIL waw_final got val=%h busy=%b want 22/0", bus.rs2_val, bus.rs2_busy);
            fails++;
        end
    endtask

    task automatic test_rollback();
        idle();
        bus.decode = 1'b1; bus.decode_rd = 5'd3; bus.decode_rob_pos = 4'd6;
        step();
        bus.decode_rd = 5'd4; bus.decode_rob_pos = 4'd7;
        step();
        idle();
        bus.rollback = 1'b1;
        bus.decode = 1'b1; bus.decode_rd = 5'd6; bus.decode_rob_pos = 4'd5;
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd3;
        bus.reg_commit_rob_pos = 4'd0; bus.reg_commit_val = 32'h77;
        step();
        idle(); bus.decode_rs1 = 5'd3; bus.decode_rs2 = 5'd4; #1;
        tests++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'h77) begin
            $display("FAIL rollback_x3 got val=%h busy=%b want 77/0", bus.rs1_val, bus.rs1_busy);
            fails++;
        end
        tests++;
        if (bus.rs2_busy !== 1'b0 || bus.rs2_rob_pos !== 4'd0) begin
            $display("FAIL rollback_x4 got busy=%b pos=%0d want 0/0", bus.rs2_busy, bus.rs2_rob_pos);
            fails++;
        end
        bus.decode_rs1 = 5'd6; #1;
        tests++;
        if (bus.rs1_busy !== 1'b0 || bus.rs1_rob_pos !== 4'd0) begin
            $display("FAIL rollback_x6 got busy=%b pos=%0d want 0/0", bus.rs1_busy, bus.rs1_rob_pos);
            fails++;
        end
    endtask

    task automatic test_x0_rdy();
        idle();
        bus.decode = 1'b1; bus.decode_rd = 5'd0; bus.decode_rob_pos = 4'd8;
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd0;
        bus.reg_commit_rob_pos = 4'd8; bus.reg_commit_val = 32'hFF;
        step();
        idle(); #1;
        tests++;
        if (bus.rs1_val !== 32'd0 || bus.rs1_busy !== 1'b0 || bus.rs1_rob_pos !== 4'd0) begin
            $display("FAIL x0_read got val=%h busy=%b pos=%0d want 0/0/0",
                     bus.rs1_val, bus.rs1_busy, bus.rs1_rob_pos);
            fails++;
        end
        rdy = 1'b0;
        bus.reg_commit = 1'b1; bus.reg_commit_rd = 5'd2; bus.reg_commit_val = 32'd5;
        bus.decode = 1'b1; bus.decode_rd = 5'd2; bus.decode_rob_pos = 4'd9;
        step();
        idle(); bus.decode_rs1 = 5'd2; #1;
        tests++;
        if (bus.rs1_val !== 32'd0 || bus.rs1_busy !== 1'b0) begin
            $display("FAIL rdy_hold got val=%h busy=%b want 0/0", bus.rs1_val, bus.rs1_busy);
            fails++;
        end
    endtask

    task automatic test_random();
        logic [31:0] ev;
        logic        eb;
        logic [3:0]  ep;
        int          crd;
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            bus.rollback = ($urandom_range(0, 24) == 0);
            bus.decode = $urandom_range(0, 1) == 1;
            bus.decode_rd = 5'($urandom_range(0, 15));
            bus.decode_rob_pos = 4'($urandom);
            bus.decode_rs1 = 5'($urandom_range(0, 15));
            bus.decode_rs2 = 5'($urandom_range(0, 15));
            crd = $urandom_range(0, 15);
            bus.reg_commit = $urandom_range(0, 2) != 0;
            bus.reg_commit_rd = 5'(crd);
            bus.reg_commit_rob_pos = ($urandom_range(0, 3) != 0) ? m_tag[crd] : 4'($urandom);
            bus.reg_commit_val = $urandom;
            #1;
            model_read(int'(bus.decode_rs1), ev, eb, ep);
            tests++;
            if (bus.rs1_val !== ev || bus.rs1_busy !== eb || bus.rs1_rob_pos !== ep) begin
                $display("FAIL rand_rs1 n=%0d rs=%0d got %h/%b/%0d want %h/%b/%0d", n,
                         bus.decode_rs1, bus.rs1_val, bus.rs1_busy, bus.rs1_rob_pos, ev, eb, ep);
                fails++;
            end
            model_read(int'(bus.decode_rs2), ev, eb, ep);
            tests++;
            if (bus.rs2_val !== ev || bus.rs2_busy !== eb || bus.rs2_rob_pos !== ep) begin
                $display("FAIL rand_rs2 n=%0d rs=%0d got %h/%b/%0d want %h/%b/%0d", n,
                         bus.decode_rs2, bus.rs2_val, bus.rs2_busy, bus.rs2_rob_pos, ev, eb, ep);
                fails++;
            end
            step();
        end
    endtask

    initial begin
        idle();
        rdy = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
        test_reset();
        test_rename_commit();
        test_bypass();
        test_waw();
        test_rollback();
        test_x0_rdy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
